// File: rtl/vme_requester.sv
// VME bus requester: BR/BG daisy-chain handling, BBSY ownership with minimum hold, bus-clear reporting.
// Optional build macro VME_RELEASE_ON_CLEAR_EN: give up the bus as soon as BCLR is seen.
module vme_requester #(
   parameter int LEVEL    = 3,
   parameter int BBSY_MIN = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       request,
   output logic       vme_br_out,
   input  logic [3:0] vme_bgin,
   output logic [3:0] vme_bgout,
   input  logic       vme_bbsy_in,
   output logic       vme_bbsy_out,
   input  logic       vme_bclr,
   input  logic       vme_as,
   output logic       bus_granted,
   output logic       bus_clear_req
);

   localparam int CNT_W = (BBSY_MIN > 1) ? $clog2(BBSY_MIN) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(BBSY_MIN - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQUEST = 3'd1,
      S_OWNER   = 3'd2,
      S_RELEASE = 3'd3,
      S_PASS    = 3'd4
   } state_t;

   state_t state, state_next;

   logic [3:0] bgin_meta, bgin_sync;
   logic       bbsy_meta, bbsy_sync;
   logic       bclr_meta, bclr_sync;
   logic       as_meta, as_sync;

   logic [CNT_W-1:0] hold_cnt, hold_cnt_next, hold_dec;
   logic [3:0]       bgout_next;
   logic             br_next, bbsy_next, pass_next;
   logic             release_on_clear, request_allowed;

   // Every bus line is asynchronous to us; idle level (high) is the reset value.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bgin_meta <= 4'hF;
         bgin_sync <= 4'hF;
         bbsy_meta <= 1'b1;
         bbsy_sync <= 1'b1;
         bclr_meta <= 1'b1;
         bclr_sync <= 1'b1;
         as_meta   <= 1'b1;
         as_sync   <= 1'b1;
      end else begin
         bgin_meta <= vme_bgin;
         bgin_sync <= bgin_meta;
         bbsy_meta <= vme_bbsy_in;
         bbsy_sync <= bbsy_meta;
         bclr_meta <= vme_bclr;
         bclr_sync <= bclr_meta;
         as_meta   <= vme_as;
         as_sync   <= as_meta;
      end
   end

`ifdef VME_RELEASE_ON_CLEAR_EN
   assign release_on_clear = ~bclr_sync;
   assign request_allowed  = bclr_sync;
`else
   assign release_on_clear = 1'b0;
   assign request_allowed  = 1'b1;
`endif

   assign hold_dec = (hold_cnt == '0) ? '0 : hold_cnt - 1'b1;

   // Next state plus next values of the registered bus drivers, so BR/BBSY/BG change cleanly on one edge.
   always_comb begin
      state_next    = state;
      hold_cnt_next = hold_cnt;
      br_next       = 1'b1;
      bbsy_next     = 1'b1;
      pass_next     = 1'b1;
      case (state)
         S_IDLE: begin
            if (!bgin_sync[LEVEL]) begin
               state_next = S_PASS;
               pass_next  = 1'b0;
            end else if (request && request_allowed) begin
               state_next = S_REQUEST;
               br_next    = 1'b0;
            end
         end
         S_PASS: begin
            if (bgin_sync[LEVEL]) begin
               state_next = S_IDLE;
            end else begin
               pass_next = 1'b0;
            end
         end
         S_REQUEST: begin
            if (!bgin_sync[LEVEL] && bbsy_sync) begin
               state_next    = request ? S_OWNER : S_RELEASE;
               bbsy_next     = 1'b0;
               hold_cnt_next = HOLD_LOAD;
            end else begin
               br_next = 1'b0;
            end
         end
         S_OWNER: begin
            bbsy_next     = 1'b0;
            hold_cnt_next = hold_dec;
            if (!request || release_on_clear) begin
               state_next = S_RELEASE;
            end
         end
         S_RELEASE: begin
            hold_cnt_next = hold_dec;
            if (hold_cnt == '0 && as_sync) begin
               state_next = S_IDLE;
            end else begin
               bbsy_next = 1'b0;
            end
         end
         default: begin
            state_next    = S_IDLE;
            hold_cnt_next = '0;
         end
      endcase
      bgout_next        = bgin_sync;
      bgout_next[LEVEL] = pass_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         hold_cnt     <= '0;
         vme_br_out   <= 1'b1;
         vme_bbsy_out <= 1'b1;
         vme_bgout    <= 4'hF;
      end else begin
         state        <= state_next;
         hold_cnt     <= hold_cnt_next;
         vme_br_out   <= br_next;
         vme_bbsy_out <= bbsy_next;
         vme_bgout    <= bgout_next;
      end
   end

   assign bus_granted   = (state == S_OWNER) && request && !release_on_clear;
   assign bus_clear_req = ((state == S_OWNER) || (state == S_RELEASE)) && !bclr_sync;

endmodule

// File: tb/tb_vme_requester.sv
// Directed self-checking bench for vme_requester (LEVEL=3, BBSY_MIN=4).
module tb_vme_requester;

   logic       clock;
   logic       reset;
   logic       request;
   logic       vme_br_out;
   logic [3:0] vme_bgin;
   logic [3:0] vme_bgout;
   logic       vme_bbsy_in;
   logic       vme_bbsy_out;
   logic       vme_bclr;
   logic       vme_as;
   logic       bus_granted;
   logic       bus_clear_req;

   int passed;
   int failed;
   int total;

   vme_requester #(.LEVEL(3), .BBSY_MIN(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .request      (request),
      .vme_br_out   (vme_br_out),
      .vme_bgin     (vme_bgin),
      .vme_bgout    (vme_bgout),
      .vme_bbsy_in  (vme_bbsy_in),
      .vme_bbsy_out (vme_bbsy_out),
      .vme_bclr     (vme_bclr),
      .vme_as       (vme_as),
      .bus_granted  (bus_granted),
      .bus_clear_req(bus_clear_req)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic req, input logic [3:0] bgin,
                                input logic bbsy_in, input logic bclr, input logic as_n);
      request     = req;
      vme_bgin    = bgin;
      vme_bbsy_in = bbsy_in;
      vme_bclr    = bclr;
      vme_as      = as_n;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      total++;
      assert (observed === expected) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   logic exp_granted_on_clear;

   initial begin
      passed = 0;
      failed = 0;
      total  = 0;
`ifdef VME_RELEASE_ON_CLEAR_EN
      exp_granted_on_clear = 1'b0;
`else
      exp_granted_on_clear = 1'b1;
`endif
      reset = 1'b1;
      applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
      #2;
      checkOutput("rst_br", vme_br_out, 1);
      checkOutput("rst_bbsy", vme_bbsy_out, 1);
      checkOutput("rst_bgout", vme_bgout, 4'hF);
      checkOutput("rst_granted", bus_granted, 0);
      checkOutput("rst_clear", bus_clear_req, 0);
      tick(2);
      reset = 1'b0;
      tick(1);

      // Request, then grant arrives five clocks later
      applyStimulus(1'b1, 4'hF, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkOutput("req_br", vme_br_out, 0);
      checkOutput("req_granted", bus_granted, 0);
      tick(4);
      checkOutput("req_br_wait", vme_br_out, 0);
      applyStimulus(1'b1, 4'h7, 1'b1, 1'b1, 1'b1);
      tick(2);
      checkOutput("grant_bbsy_pre", vme_bbsy_out, 1);
      checkOutput("grant_br_pre", vme_br_out, 0);
      tick(1);
      checkOutput("own_bbsy", vme_bbsy_out, 0);
      checkOutput("own_br", vme_br_out, 1);
      checkOutput("own_granted", bus_granted, 1);
      checkOutput("own_bgout", vme_bgout, 4'hF);
      checkOutput("own_clear", bus_clear_req, 0);

      // Reset mid-ownership acts before the next edge
      reset = 1'b1;
      #2;
      checkOutput("rst_own_bbsy", vme_bbsy_out, 1);
      checkOutput("rst_own_bgout", vme_bgout, 4'hF);
      checkOutput("rst_own_granted", bus_granted, 0);
      checkOutput("rst_own_br", vme_br_out, 1);
      applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
      tick(1);
      reset = 1'b0;
      tick(1);

      // Bus clear while owner
      applyStimulus(1'b1, 4'h7, 1'b1, 1'b1, 1'b1);
      tick(3);
      checkOutput("clr_own_bbsy", vme_bbsy_out, 0);
      checkOutput("clr_own_granted", bus_granted, 1);
      applyStimulus(1'b1, 4'h7, 1'b1, 1'b0, 1'b1);
      tick(2);
      checkOutput("clr_req", bus_clear_req, 1);
      tick(1);
      checkOutput("clr_granted", bus_granted, exp_granted_on_clear);
      checkOutput("clr_req_hold", bus_clear_req, 1);
      reset = 1'b1;
      applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
      tick(1);
      reset = 1'b0;
      tick(1);

      // Release while AS still low: BBSY held until AS seen high
      applyStimulus(1'b1, 4'h7, 1'b1, 1'b1, 1'b1);
      tick(3);
      checkOutput("as_own_bbsy", vme_bbsy_out, 0);
      applyStimulus(1'b1, 4'h7, 1'b1, 1'b1, 1'b0);
      tick(1);
      applyStimulus(1'b0, 4'h7, 1'b1, 1'b1, 1'b0);
      tick(1);
      checkOutput("as_rel_granted", bus_granted, 0);
      for (int i = 0; i < 6; i++) begin
         tick(1);
         checkOutput("as_low_bbsy", vme_bbsy_out, 0);
      end
      applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
      tick(2);
      checkOutput("as_sync_bbsy", vme_bbsy_out, 0);
      tick(1);
      checkOutput("as_done_bbsy", vme_bbsy_out, 1);
      checkOutput("as_done_br", vme_br_out, 1);

      // Request dropped while waiting; BBSY busy delays the grant; minimum hold of 4 clocks
      applyStimulus(1'b1, 4'hF, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkOutput("drop_br", vme_br_out, 0);
      applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
      tick(2);
      checkOutput("drop_br_hold", vme_br_out, 0);
      applyStimulus(1'b0, 4'h7, 1'b0, 1'b1, 1'b1);
      tick(3);
      checkOutput("busy_br", vme_br_out, 0);
      checkOutput("busy_bbsy", vme_bbsy_out, 1);
      applyStimulus(1'b0, 4'h7, 1'b1, 1'b1, 1'b1);
      tick(2);
      checkOutput("free_bbsy_pre", vme_bbsy_out, 1);
      tick(1);
      checkOutput("drop_rel_bbsy", vme_bbsy_out, 0);
      checkOutput("drop_rel_br", vme_br_out, 1);
      checkOutput("drop_rel_granted", bus_granted, 0);
      applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
      tick(3);
      checkOutput("min_hold_bbsy", vme_bbsy_out, 0);
      tick(1);
      checkOutput("min_done_bbsy", vme_bbsy_out, 1);

      // Grant passed down the chain for 10 clocks
      applyStimulus(1'b0, 4'h7, 1'b1, 1'b1, 1'b1);
      tick(2);
      checkOutput("pass_lat_pre", vme_bgout, 4'hF);
      tick(1);
      checkOutput("pass_bgout", vme_bgout, 4'h7);
      checkOutput("pass_br", vme_br_out, 1);
      checkOutput("pass_bbsy", vme_bbsy_out, 1);
      tick(7);
      checkOutput("pass_hold", vme_bgout, 4'h7);
      applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
      tick(2);
      checkOutput("pass_end_pre", vme_bgout, 4'h7);
      tick(1);
      checkOutput("pass_end", vme_bgout, 4'hF);

      // Other-level grants are plain 3-clock pass-through
      applyStimulus(1'b0, 4'hE, 1'b1, 1'b1, 1'b1);
      tick(2);
      checkOutput("thru_pre", vme_bgout, 4'hF);
      tick(1);
      checkOutput("thru_bgout", vme_bgout, 4'hE);
      applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
      tick(3);
      checkOutput("thru_end", vme_bgout, 4'hF);

      // Incoming grant wins over a simultaneous local request
      applyStimulus(1'b0, 4'h7, 1'b1, 1'b1, 1'b1);
      tick(2);
      applyStimulus(1'b1, 4'h7, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkOutput("prio_bgout", vme_bgout, 4'h7);
      checkOutput("prio_br", vme_br_out, 1);
      tick(3);
      checkOutput("prio_br_hold", vme_br_out, 1);
      checkOutput("prio_bgout_hold", vme_bgout, 4'h7);
      applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
      tick(3);
      checkOutput("prio_end_bgout", vme_bgout, 4'hF);
      checkOutput("prio_end_br", vme_br_out, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
